// File: rtl/sdram_burst_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : sdram_burst_fifo_if
// Description : Data/handshake/status bundle for sdram_burst_fifo.
//               Error flags are present only with SDRAM_FIFO_ERRFLAG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface sdram_burst_fifo_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 6
) ();
    logic [WIDTH-1:0]  data;
    logic              wrreq;
    logic              rdreq;
    logic [WIDTH-1:0]  q;
    logic [ADDR_W:0]   usedw;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              almost_empty;
    logic              burst_rdy;
`ifdef SDRAM_FIFO_ERRFLAG_EN
    logic              ovf_err;
    logic              udf_err;

    modport master (
        output data, wrreq, rdreq,
        input  q, usedw, empty, full, almost_full, almost_empty, burst_rdy,
        input  ovf_err, udf_err
    );
    modport slave (
        input  data, wrreq, rdreq,
        output q, usedw, empty, full, almost_full, almost_empty, burst_rdy,
        output ovf_err, udf_err
    );
`else
    modport master (
        output data, wrreq, rdreq,
        input  q, usedw, empty, full, almost_full, almost_empty, burst_rdy
    );
    modport slave (
        input  data, wrreq, rdreq,
        output q, usedw, empty, full, almost_full, almost_empty, burst_rdy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/sdram_burst_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sdram_burst_fifo
// Description : Single-clock block-RAM FIFO with registered level flags and
//               normal/showahead read; SDRAM_FIFO_ERRFLAG_EN adds sticky
//               overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_burst_fifo #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = 6,
    parameter int SHOWAHEAD = 0,
    parameter int BURST_LEN = 8,
    parameter int AF_LEVEL  = 56,
    parameter int AE_LEVEL  = 8
) (
    input  wire logic          clock,
    input  wire logic          aclr_n,
    input  wire logic          sclr,
    sdram_burst_fifo_if.slave  bus
);
    localparam logic [ADDR_W:0]   c_depth = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_af    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0]   c_ae    = (ADDR_W+1)'(AE_LEVEL);
    localparam logic [ADDR_W:0]   c_burst = (ADDR_W+1)'(BURST_LEN);
    localparam logic [ADDR_W:0]   c_one   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_pinc  = ADDR_W'(1);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] w_rd_ptr_nxt;
    logic [ADDR_W:0]   r_usedw;
    logic [ADDR_W:0]   w_usedw_nxt;
    logic              r_empty, r_full, r_af, r_ae, r_burst;
    logic              w_empty_nxt;
    logic              w_wr_acc, w_rd_acc;
    logic [WIDTH-1:0]  r_q;

    always_comb begin
        w_rd_acc     = bus.rdreq && !r_empty && !sclr;
        w_wr_acc     = bus.wrreq && (!r_full || w_rd_acc) && !sclr;
        w_rd_ptr_nxt = r_rd_ptr + ADDR_W'(w_rd_acc);
        w_usedw_nxt  = r_usedw;
        if (w_wr_acc && !w_rd_acc)
            w_usedw_nxt = r_usedw + c_one;
        else if (!w_wr_acc && w_rd_acc)
            w_usedw_nxt = r_usedw - c_one;
        // The word written on this edge is not readable until the next one.
        w_empty_nxt  = (w_usedw_nxt == (ADDR_W+1)'(w_wr_acc));
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usedw  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
            r_burst  <= 1'b0;
        end else if (sclr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usedw  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
            r_burst  <= 1'b0;
        end else begin
            if (w_wr_acc)
                r_wr_ptr <= r_wr_ptr + c_pinc;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_usedw  <= w_usedw_nxt;
            r_empty  <= w_empty_nxt;
            r_full   <= (w_usedw_nxt == c_depth);
            r_af     <= (w_usedw_nxt >= c_af);
            r_ae     <= (w_usedw_nxt <= c_ae);
            r_burst  <= (w_usedw_nxt >= c_burst);
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr_acc)
            r_mem[r_wr_ptr] <= bus.data;
    end

    generate
        if (SHOWAHEAD != 0) begin : g_showahead
            // Prefetch the upcoming head so q tracks it with no bubble.
            always_ff @(posedge clock or negedge aclr_n) begin
                if (!aclr_n)
                    r_q <= '0;
                else if (!sclr && !w_empty_nxt)
                    r_q <= r_mem[w_rd_ptr_nxt];
            end
        end else begin : g_normal
            always_ff @(posedge clock or negedge aclr_n) begin
                if (!aclr_n)
                    r_q <= '0;
                else if (w_rd_acc)
                    r_q <= r_mem[r_rd_ptr];
            end
        end
    endgenerate

`ifdef SDRAM_FIFO_ERRFLAG_EN
    logic r_ovf, r_udf;

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else if (sclr) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (bus.wrreq && r_full && !w_rd_acc)
                r_ovf <= 1'b1;
            if (bus.rdreq && r_empty)
                r_udf <= 1'b1;
        end
    end

    assign bus.ovf_err = r_ovf;
    assign bus.udf_err = r_udf;
`endif

    assign bus.q            = r_q;
    assign bus.usedw        = r_usedw;
    assign bus.empty        = r_empty;
    assign bus.full         = r_full;
    assign bus.almost_full  = r_af;
    assign bus.almost_empty = r_ae;
    assign bus.burst_rdy    = r_burst;
endmodule
`default_nettype wire
